mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator side of the word-addressed memory interface (mem_enable / mem_op / MAR / MBR_out / MBR_in, 1-cycle read latency).
- Sits between the processor core and the memory block.
- Arbitrates between an instruction-fetch client (read-only) and a data client (read/write).
- Sequences each access with the correct latency, range-checks addresses and returns one response per accepted request.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the attached memory; legal addresses 0..MEM_WORDS-1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch client requests a read
if_req_addr  in  32  fetch word address
if_req_ready  out  1  fetch request accepted this cycle when valid&ready
if_resp_valid  out  1  one-cycle pulse: fetch response on resp_rdata/resp_err
d_req_valid  in  1  data client request
d_req_write  in  1  0=read, 1=write
d_req_addr  in  32  data word address
d_req_wdata  in  32  write data
d_req_ready  out  1  data request accepted when valid&ready
d_resp_valid  out  1  one-cycle pulse: data response on resp_rdata/resp_err
resp_rdata  out  32  read data (0 for writes and errors)
resp_err  out  1  address out of range
mem_enable  out  1  memory access strobe
mem_op  out  1  0=read, 1=write
MAR  out  32  memory word address
MBR_out  out  32  memory write data
MBR_in  in  32  memory read data, valid 1 cycle after read strobe

Behaviour:
- Reset (clock edge with reset=1): state IDLE. All outputs 0: mem_enable, mem_op, MAR, MBR_out, resp_rdata, resp_err, both resp_valid, both req_ready. Arbitration pointer set to "data first". Any in-flight request is dropped with no response. A write strobed in the same cycle as reset may still complete in memory; this is accepted.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Ready depends combinationally on valid and state. Only one ready is high, and only in IDLE.
  - Only one client valid: that client's ready=1.
  - Both valid: the pointer picks the winner, and the pointer flips to the other client after each contended grant. Uncontended grants leave the pointer unchanged.
  - On accept: latch client id, op (fetch always read), address and wdata.
  - Range check: address >= MEM_WORDS, unsigned 32-bit compare, goes to RESP with err=1. No memory access is made.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle): mem_enable=1; mem_op, MAR and MBR_out driven from registers.
  - Write goes to RESP.
  - Read goes to WAIT.
- WAIT (1 cycle): mem_enable=0; capture MBR_in into resp_rdata; go to RESP.
- RESP (1 cycle): the owning client's resp_valid=1, with resp_rdata and resp_err stable. Then go to IDLE.
- Outside RESP, both resp_valid=0.
- resp_rdata is 0 for write and error responses. resp_err is cleared on every non-error response.
- Latency, with accept at cycle T:
  - Read: mem_enable at T+1, resp_valid at T+3.
  - Write: mem_enable at T+1, resp_valid at T+2.
  - Error: resp_valid at T+1.
- Next accept is possible in the cycle after RESP. Throughput is 1 read per 4 cycles or 1 write per 3 cycles.
- mem_enable is high only in ACCESS. MAR, MBR_out and mem_op hold their last values otherwise.
- Request inputs are ignored outside IDLE. Clients hold valid until ready.
- There is no cancellation; the response is always delivered unless reset occurs.

Test Plan:
- Reset, then data write addr=5, wdata=0xDEADBEEF. Accept at T -> mem_enable=1, mem_op=1, MAR=5, MBR_out=0xDEADBEEF at T+1 only; d_resp_valid at T+2 with rdata=0, err=0.
- Data read addr=5 after that write -> mem_enable=1, mem_op=0 at T+1; d_resp_valid at T+3 with resp_rdata=0xDEADBEEF.
- Fetch addr=1024 and addr=0xFFFFFFFF (MEM_WORDS=1024) -> if_resp_valid at T+1 with err=1, rdata=0; mem_enable never asserted.
- Both clients valid continuously, reads at addr 10 (data) and 20 (fetch) -> grants alternate D,F,D,F; responses routed to the matching resp_valid; no grant overlap.
- Reset asserted during WAIT of a read -> next cycle all outputs 0, state IDLE, no resp_valid pulse; a new request is accepted the following cycle.
- Fetch-only stream of 4 reads (addrs 0..3, preloaded 0x100..0x103) -> responses 0x100..0x103 at 4-cycle spacing; d_req_ready stays 0 throughout.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch and data clients onto a single
// word-addressed memory port with 1-cycle read latency, one response per request.
module mem_access_ctrl #(
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_resp_valid,
   input  logic        d_req_valid,
   input  logic        d_req_write,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_enable,
   output logic        mem_op,
   output logic [31:0] MAR,
   output logic [31:0] MBR_out,
   input  logic [31:0] MBR_in
);

   // state  | meaning
   // IDLE   | waiting for a request, readies may assert
   // ACCESS | memory strobe driven for one cycle
   // WAIT   | read data returning on MBR_in, captured here
   // RESP   | response pulse to the owning client
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;        // 0: data wins next contention, 1: fetch wins
   logic        client_q, client_d;  // 1: current request belongs to fetch client
   logic        op_q, op_d;
   logic [31:0] mar_q, mar_d;
   logic [31:0] mbr_out_q, mbr_out_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        grant_d, grant_f;
   logic [31:0] req_addr;
   logic        req_wr;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      client_d     = client_q;
      op_d         = op_q;
      mar_d        = mar_q;
      mbr_out_d    = mbr_out_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      grant_d      = d_req_valid && (!if_req_valid || !ptr_q);
      grant_f      = if_req_valid && (!d_req_valid || ptr_q);
      req_addr     = grant_f ? if_req_addr : d_req_addr;
      req_wr       = grant_d && d_req_write;

      case (state_q)
         IDLE: begin
            d_req_ready  = grant_d && !reset;
            if_req_ready = grant_f && !reset;
            if (grant_d || grant_f) begin
               client_d = grant_f;
               if (d_req_valid && if_req_valid)
                  ptr_d = ~ptr_q;
               rdata_d = '0;
               err_d   = (req_addr >= 32'(MEM_WORDS));
               if (req_addr >= 32'(MEM_WORDS)) begin
                  state_d = RESP;
               end else begin
                  // memory-side registers only change for accesses that are made
                  mar_d   = req_addr;
                  op_d    = req_wr;
                  if (req_wr)
                     mbr_out_d = d_req_wdata;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: state_d = op_q ? RESP : WAIT;
         WAIT: begin
            rdata_d = MBR_in;
            state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b0;
         client_q  <= 1'b0;
         op_q      <= 1'b0;
         mar_q     <= '0;
         mbr_out_q <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         client_q  <= client_d;
         op_q      <= op_d;
         mar_q     <= mar_d;
         mbr_out_q <= mbr_out_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign mem_enable    = (state_q == ACCESS);
   assign mem_op        = op_q;
   assign MAR           = mar_q;
   assign MBR_out       = mbr_out_q;
   assign resp_rdata    = rdata_q;
   assign resp_err      = err_q;
   assign if_resp_valid = (state_q == RESP) && client_q;
   assign d_resp_valid  = (state_q == RESP) && !client_q;

endmodule
